// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: write-pointer synchroniser, read pointer,
// dpram read port and the empty / almost-empty / count / underflow flags (standard or FWFT).
module async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH      = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int FWFT            = 0,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] iv_wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] ov_rd_ptr_gray,
  output logic [ADDR_WIDTH-2:0] ov_rd_addr_dpram,
  output logic                  o_dpram_rd_en,
  output logic                  o_valid,
  output logic                  o_fifo_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH-1:0] ov_rd_count,
  output logic                  o_underflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] AE_TH = AW'(ALMOST_EMPTY_TH);

  logic [AW-1:0] sync_q [SYNC_STAGES];
  logic [AW-1:0] wr_bin_sync;
  logic [AW-1:0] rd_ptr_bin;
  logic [AW-1:0] rd_ptr_bin_next;
  logic [AW-1:0] rd_ptr_gray;
  logic [AW-1:0] rd_count;
  logic [AW-1:0] count_next;
  logic          valid_q;
  logic          show_q;
  logic          show_next;
  logic          underflow_q;
  logic          mem_empty;
  logic          rd_grant;
  logic          pop;
  logic          fifo_empty;

  function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b[AW-1] = g[AW-1];
    for (int i = AW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // mem_empty compares two registers only, so the flags never see an unsynchronised pointer
  always_comb begin
    mem_empty  = (rd_ptr_bin == wr_bin_sync);
    pop        = 1'b0;
    show_next  = 1'b0;
    rd_grant   = 1'b0;
    fifo_empty = mem_empty;
    if (FWFT != 0) begin
      pop        = i_rd_en & show_q;
      rd_grant   = ~mem_empty & (~show_q | pop);
      show_next  = rd_grant | (show_q & ~pop);
      fifo_empty = ~show_q;
    end else begin
      rd_grant   = i_rd_en & ~mem_empty;
      fifo_empty = mem_empty;
    end
    rd_ptr_bin_next = rd_ptr_bin + {{(AW-1){1'b0}}, rd_grant};
    count_next      = wr_bin_sync - rd_ptr_bin_next + {{(AW-1){1'b0}}, show_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      wr_bin_sync <= '0;
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
      rd_count    <= '0;
      valid_q     <= 1'b0;
      show_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sync_q[0] <= iv_wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_bin_sync <= gray2bin(sync_q[SYNC_STAGES-1]);
      rd_ptr_bin  <= rd_ptr_bin_next;
      rd_ptr_gray <= rd_ptr_bin_next ^ (rd_ptr_bin_next >> 1);
      rd_count    <= count_next;
      valid_q     <= rd_grant;
      show_q      <= show_next;
      underflow_q <= i_rd_en & fifo_empty;
    end
  end

  assign ov_rd_ptr_gray   = rd_ptr_gray;
  assign ov_rd_addr_dpram = rd_ptr_bin[AW-2:0];
  assign o_dpram_rd_en    = rd_grant;
  assign o_valid          = (FWFT != 0) ? show_q : valid_q;
  assign o_fifo_empty     = fifo_empty;
  assign o_almost_empty   = (rd_count <= AE_TH);
  assign ov_rd_count      = rd_count;
  assign o_underflow      = underflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: one standard-mode and one FWFT instance, directed scenarios
// plus random traffic checked against an occupancy-based reference model.
module tb_async_fifo_rd_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_en_s = 1'b0, rd_en_f = 1'b0;
  int   wr_bin_s = 0, wr_bin_f = 0;
  logic [4:0] s_wr_gray, f_wr_gray;
  logic [4:0] s_gray, f_gray, s_cnt, f_cnt;
  logic [3:0] s_addr, f_addr;
  logic s_rden, f_rden, s_valid, f_valid, s_empty, f_empty, s_ae, f_ae, s_uf, f_uf;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  assign s_wr_gray = g5(wr_bin_s);
  assign f_wr_gray = g5(wr_bin_f);

  async_fifo_rd_ctrl #(.ADDR_WIDTH(5), .SYNC_STAGES(2), .FWFT(0), .ALMOST_EMPTY_TH(2)) u_std (
    .clk(clk), .reset(reset), .i_rd_en(rd_en_s), .iv_wr_ptr_gray(s_wr_gray),
    .ov_rd_ptr_gray(s_gray), .ov_rd_addr_dpram(s_addr), .o_dpram_rd_en(s_rden),
    .o_valid(s_valid), .o_fifo_empty(s_empty), .o_almost_empty(s_ae),
    .ov_rd_count(s_cnt), .o_underflow(s_uf));

  async_fifo_rd_ctrl #(.ADDR_WIDTH(5), .SYNC_STAGES(2), .FWFT(1), .ALMOST_EMPTY_TH(2)) u_fwft (
    .clk(clk), .reset(reset), .i_rd_en(rd_en_f), .iv_wr_ptr_gray(f_wr_gray),
    .ov_rd_ptr_gray(f_gray), .ov_rd_addr_dpram(f_addr), .o_dpram_rd_en(f_rden),
    .o_valid(f_valid), .o_fifo_empty(f_empty), .o_almost_empty(f_ae),
    .ov_rd_count(f_cnt), .o_underflow(f_uf));

  logic a_rden[2], a_valid[2], a_empty[2], a_ae[2], a_uf[2];
  logic [3:0] a_addr[2];
  logic [4:0] a_cnt[2], a_gray[2];
  assign a_rden[0] = s_rden;   assign a_rden[1] = f_rden;
  assign a_valid[0] = s_valid; assign a_valid[1] = f_valid;
  assign a_empty[0] = s_empty; assign a_empty[1] = f_empty;
  assign a_ae[0] = s_ae;       assign a_ae[1] = f_ae;
  assign a_uf[0] = s_uf;       assign a_uf[1] = f_uf;
  assign a_addr[0] = s_addr;   assign a_addr[1] = f_addr;
  assign a_cnt[0] = s_cnt;     assign a_cnt[1] = f_cnt;
  assign a_gray[0] = s_gray;   assign a_gray[1] = f_gray;

  // Reference model: words the read side can see = write pointer as it stood three edges
  // ago minus words already taken out of memory; FWFT adds the word being shown.
  int m_rd[2];
  int m_hist[2][3];
  bit m_v[2];
  bit m_uf[2];
  int m_cnt[2];

  function automatic bit m_rd_en(input int k);
    return (k == 0) ? bit'(rd_en_s) : bit'(rd_en_f);
  endfunction
  function automatic int m_wr(input int k);
    return (k == 0) ? wr_bin_s : wr_bin_f;
  endfunction
  function automatic int avail(input int k);
    return (m_hist[k][0] - m_rd[k]) & 31;
  endfunction
  function automatic bit m_empty(input int k);
    return (k == 0) ? (avail(0) == 0) : !m_v[1];
  endfunction
  function automatic bit m_grant(input int k);
    if (avail(k) == 0) return 1'b0;
    return (k == 0) ? m_rd_en(0) : (!m_v[1] || m_rd_en(1));
  endfunction

  task automatic cyc();
    bit g, e, pop;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_rd[k] = 0; m_v[k] = 0; m_uf[k] = 0; m_cnt[k] = 0;
        for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
      end else begin
        g = m_grant(k);
        e = m_empty(k);
        pop = (k == 1) && m_rd_en(1) && m_v[1];
        m_uf[k] = m_rd_en(k) && e;
        m_rd[k] = (m_rd[k] + int'(g)) & 31;
        if (k == 0) m_v[0] = g;
        else m_v[1] = g || (m_v[1] && !pop);
        m_cnt[k] = ((m_hist[k][0] - m_rd[k]) & 31) + ((k == 1) ? int'(m_v[1]) : 0);
        m_hist[k][0] = m_hist[k][1];
        m_hist[k][1] = m_hist[k][2];
        m_hist[k][2] = m_wr(k) & 31;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_en_s = 1'b0; rd_en_f = 1'b0; wr_bin_s = 0; wr_bin_f = 0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_empty[k] !== 1'b1 || a_ae[k] !== 1'b1 || a_cnt[k] !== 5'd0 ||
            a_gray[k] !== 5'd0 || a_valid[k] !== 1'b0 || a_uf[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_state dut%0d cyc%0d: empty=%0b ae=%0b cnt=%0d gray=%0d valid=%0b uf=%0b want 1 1 0 0 0 0",
                   k, i, a_empty[k], a_ae[k], a_cnt[k], a_gray[k], a_valid[k], a_uf[k]);
        end
      end
      if (i < 3) cyc();
    end
  endtask

  task automatic test_std_single();
    wr_bin_s = 1;
    cyc(); cyc();
    checks++;
    if (s_empty !== 1'b1) begin failures++; $display("FAIL std_empty_early: got %0b want 1", s_empty); end
    cyc();
    checks++;
    if (s_empty !== 1'b0) begin failures++; $display("FAIL std_empty_latency: got %0b want 0", s_empty); end
    cyc();
    checks++;
    if (s_cnt !== 5'd1) begin failures++; $display("FAIL std_count1: got %0d want 1", s_cnt); end
    rd_en_s = 1'b1;
    #1;
    checks++;
    if (s_rden !== 1'b1 || s_addr !== 4'd0) begin
      failures++; $display("FAIL std_single_rd: rden=%0b addr=%0d want 1 0", s_rden, s_addr);
    end
    cyc();
    rd_en_s = 1'b0;
    checks++;
    if (s_valid !== 1'b1 || s_empty !== 1'b1 || s_gray !== 5'd1 || s_cnt !== 5'd0 || s_uf !== 1'b0) begin
      failures++;
      $display("FAIL std_single_after: valid=%0b empty=%0b gray=%0d cnt=%0d uf=%0b want 1 1 1 0 0",
               s_valid, s_empty, s_gray, s_cnt, s_uf);
    end
  endtask

  task automatic test_std_burst();
    do_reset();
    wr_bin_s = 16;
    repeat (4) cyc();
    checks++;
    if (s_cnt !== 5'd16 || s_ae !== 1'b0) begin
      failures++; $display("FAIL burst_full: cnt=%0d ae=%0b want 16 0", s_cnt, s_ae);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en_s = 1'b1;
      #1;
      checks++;
      if (s_rden !== 1'b1 || s_addr !== 4'(i)) begin
        failures++; $display("FAIL burst_rd%0d: rden=%0b addr=%0d want 1 %0d", i, s_rden, s_addr, i);
      end
      cyc();
      checks++;
      if (s_gray !== g5(i + 1) || s_uf !== 1'b0) begin
        failures++; $display("FAIL burst_ptr%0d: gray=%0d uf=%0b want %0d 0", i, s_gray, s_uf, g5(i + 1));
      end
    end
    rd_en_s = 1'b0;
    checks++;
    if (s_empty !== 1'b1 || s_cnt !== 5'd0 || s_ae !== 1'b1) begin
      failures++; $display("FAIL burst_end: empty=%0b cnt=%0d ae=%0b want 1 0 1", s_empty, s_cnt, s_ae);
    end
  endtask

  task automatic test_wrap();
    int exp_a[4] = '{14, 15, 0, 1};
    int exp_p[4] = '{31, 0, 1, 2};
    wr_bin_s = 30;
    repeat (4) cyc();
    rd_en_s = 1'b1;
    repeat (14) cyc();
    rd_en_s = 1'b0;
    checks++;
    if (s_gray !== g5(30) || s_empty !== 1'b1) begin
      failures++; $display("FAIL wrap_pre: gray=%0d empty=%0b want %0d 1", s_gray, s_empty, g5(30));
    end
    wr_bin_s = 2;
    repeat (4) cyc();
    checks++;
    if (s_cnt !== 5'd4 || s_ae !== 1'b0) begin
      failures++; $display("FAIL wrap_count: cnt=%0d ae=%0b want 4 0", s_cnt, s_ae);
    end
    for (int i = 0; i < 4; i++) begin
      rd_en_s = 1'b1;
      #1;
      checks++;
      if (s_rden !== 1'b1 || s_addr !== 4'(exp_a[i])) begin
        failures++; $display("FAIL wrap_addr%0d: rden=%0b addr=%0d want 1 %0d", i, s_rden, s_addr, exp_a[i]);
      end
      cyc();
      checks++;
      if (s_gray !== g5(exp_p[i]) || s_cnt !== 5'(3 - i)) begin
        failures++;
        $display("FAIL wrap_ptr%0d: gray=%0d cnt=%0d want %0d %0d", i, s_gray, s_cnt, g5(exp_p[i]), 3 - i);
      end
    end
    rd_en_s = 1'b0;
  endtask

  task automatic test_underflow();
    rd_en_s = 1'b1; rd_en_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (s_rden !== 1'b0 || f_rden !== 1'b0) begin
        failures++; $display("FAIL uf_rden%0d: std=%0b fwft=%0b want 0 0", i, s_rden, f_rden);
      end
      cyc();
      checks++;
      if (s_uf !== 1'b1 || f_uf !== 1'b1 || s_gray !== g5(2) || s_cnt !== 5'd0 || f_gray !== 5'd0) begin
        failures++;
        $display("FAIL uf_pulse%0d: uf=%0b/%0b gray=%0d/%0d cnt=%0d want 1/1 %0d/0 0",
                 i, s_uf, f_uf, s_gray, f_gray, s_cnt, g5(2));
      end
    end
    rd_en_s = 1'b0; rd_en_f = 1'b0;
    cyc();
    checks++;
    if (s_uf !== 1'b0 || f_uf !== 1'b0) begin
      failures++; $display("FAIL uf_clear: uf=%0b/%0b want 0/0", s_uf, f_uf);
    end
    wr_bin_s = 10;
    repeat (4) cyc();
    rd_en_s = 1'b1;
    repeat (2) cyc();
    reset = 1'b1; wr_bin_s = 0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (s_valid !== 1'b0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_cnt !== 5'd0 ||
          s_gray !== 5'd0 || s_uf !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset%0d: valid=%0b empty=%0b ae=%0b cnt=%0d gray=%0d uf=%0b want 0 1 1 0 0 0",
                 i, s_valid, s_empty, s_ae, s_cnt, s_gray, s_uf);
      end
      reset = 1'b0; rd_en_s = 1'b0;
      if (i == 0) cyc();
    end
  endtask

  task automatic test_fwft();
    do_reset();
    wr_bin_f = 3;
    cyc(); cyc();
    #1;
    checks++;
    if (f_rden !== 1'b0 || f_empty !== 1'b1) begin
      failures++; $display("FAIL fwft_early: rden=%0b empty=%0b want 0 1", f_rden, f_empty);
    end
    cyc();
    #1;
    checks++;
    if (f_rden !== 1'b1 || f_addr !== 4'd0 || f_empty !== 1'b1) begin
      failures++; $display("FAIL fwft_prefetch: rden=%0b addr=%0d empty=%0b want 1 0 1", f_rden, f_addr, f_empty);
    end
    cyc();
    checks++;
    if (f_empty !== 1'b0 || f_valid !== 1'b1 || f_cnt !== 5'd3) begin
      failures++; $display("FAIL fwft_shown: empty=%0b valid=%0b cnt=%0d want 0 1 3", f_empty, f_valid, f_cnt);
    end
    rd_en_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (f_rden !== (i < 2) || (i < 2 && f_addr !== 4'(i + 1)) || f_empty !== 1'b0) begin
        failures++;
        $display("FAIL fwft_pop%0d: rden=%0b addr=%0d empty=%0b want %0b %0d 0", i, f_rden, f_addr, f_empty, i < 2, i + 1);
      end
      cyc();
    end
    rd_en_f = 1'b0;
    checks++;
    if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_cnt !== 5'd0 || f_gray !== g5(3) || f_uf !== 1'b0) begin
      failures++;
      $display("FAIL fwft_drained: empty=%0b valid=%0b cnt=%0d gray=%0d uf=%0b want 1 0 0 %0d 0",
               f_empty, f_valid, f_cnt, f_gray, f_uf, g5(3));
    end
  endtask

  task automatic test_random();
    int inc, space;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rd_en_s = ($urandom_range(0, 99) < 45);
      rd_en_f = ($urandom_range(0, 99) < 45);
      space = 16 - ((wr_bin_s - m_rd[0]) & 31);
      inc = $urandom_range(0, 2);
      wr_bin_s = (wr_bin_s + ((inc < space) ? inc : space)) & 31;
      space = 16 - ((wr_bin_f - m_rd[1]) & 31);
      inc = $urandom_range(0, 2);
      wr_bin_f = (wr_bin_f + ((inc < space) ? inc : space)) & 31;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rden[k] !== m_grant(k) || a_addr[k] !== 4'(m_rd[k] & 15) || a_valid[k] !== m_v[k] ||
            a_empty[k] !== m_empty(k) || a_cnt[k] !== 5'(m_cnt[k]) || a_ae[k] !== (m_cnt[k] <= 2) ||
            a_gray[k] !== g5(m_rd[k]) || a_uf[k] !== m_uf[k]) begin
          failures++;
          $display("FAIL rand dut%0d n%0d: rden=%0b addr=%0d valid=%0b empty=%0b cnt=%0d ae=%0b gray=%0d uf=%0b want %0b %0d %0b %0b %0d %0b %0d %0b",
                   k, n, a_rden[k], a_addr[k], a_valid[k], a_empty[k], a_cnt[k], a_ae[k], a_gray[k], a_uf[k],
                   m_grant(k), m_rd[k] & 15, m_v[k], m_empty(k), m_cnt[k], m_cnt[k] <= 2, g5(m_rd[k]), m_uf[k]);
        end
      end
      cyc();
    end
    rd_en_s = 1'b0; rd_en_f = 1'b0;
  endtask

  initial begin
    test_reset();
    test_std_single();
    test_std_burst();
    test_wrap();
    test_underflow();
    test_fwft();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
